// File: rtl/fifo_reader.sv
// Pop-side engine: drains a show-ahead FIFO into a 2-entry output buffer and
// presents the words on a valid/ready stream; flush discards pending FIFO words.
module fifo_reader #(
  parameter int BITS  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             fifo_pnding_i,
  input  logic [BITS-1:0]  fifo_data_i,
  output logic             fifo_pop_o,
  output logic [BITS-1:0]  data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic             flush_done_o
);

  // state | meaning
  // IDLE  | no new pops; buffered words may still drain downstream
  // RUN   | pop FIFO whenever the output buffer has room
  // FLUSH | pop and discard until the FIFO reports empty
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic [BITS-1:0]   buf0, buf1;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  cnt;
  logic              done;

  logic              hs, wr, flush_entry;
  logic [BITS-1:0]   buf0_n, buf1_n;
  logic [1:0]        occ_n;

  always_comb begin
    fifo_pop_o = 1'b0;
    if (!rst_i) begin
      case (state)
        RUN:     fifo_pop_o = fifo_pnding_i && (occ != 2'd2);
        FLUSH:   fifo_pop_o = fifo_pnding_i;
        default: fifo_pop_o = 1'b0;
      endcase
    end
  end

  assign valid_o     = (occ != 2'd0);
  assign hs          = valid_o && ready_i;
  assign wr          = fifo_pop_o && (state == RUN);
  assign flush_entry = flush_i && (state != FLUSH);

  // buf0 is always the head; buf1 only holds the second word when occ==2
  always_comb begin
    buf0_n = buf0;
    buf1_n = buf1;
    occ_n  = occ;
    if (flush_entry) begin
      occ_n = 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (wr) begin
            buf0_n = fifo_data_i;
            occ_n  = 2'd1;
          end
        end
        2'd1: begin
          if (hs && wr) begin
            buf0_n = fifo_data_i;
          end else if (hs) begin
            occ_n = 2'd0;
          end else if (wr) begin
            buf1_n = fifo_data_i;
            occ_n  = 2'd2;
          end
        end
        default: begin
          if (hs) begin
            buf0_n = buf1;
            occ_n  = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      buf0  <= '0;
      buf1  <= '0;
      occ   <= 2'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      buf0 <= buf0_n;
      buf1 <= buf1_n;
      occ  <= occ_n;
      done <= 1'b0;
      if (hs && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (flush_i)   state <= FLUSH;
          else if (en_i) state <= RUN;
        end
        RUN: begin
          if (flush_i)    state <= FLUSH;
          else if (!en_i) state <= IDLE;
        end
        FLUSH: begin
          if (!fifo_pnding_i) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_o       = buf0;
  assign busy_o       = (state != IDLE) || (occ != 2'd0);
  assign word_cnt_o   = cnt;
  assign flush_done_o = done;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue stands in for the FIFO, and a scoreboard of
// popped-but-undelivered words predicts the stream.
module tb_fifo_reader;
  localparam int BITS  = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst, en, flush, pnding, pop, valid, ready, busy, done;
  logic [BITS-1:0]  fdata, data;
  logic [CNT_W-1:0] cnt;

  fifo_reader #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .fifo_pnding_i(pnding), .fifo_data_i(fdata), .fifo_pop_o(pop),
    .data_o(data), .valid_o(valid), .ready_i(ready), .busy_o(busy),
    .word_cnt_o(cnt), .flush_done_o(done)
  );

  always #5 clk = ~clk;

  logic [31:0] fq[$];
  logic [31:0] sb[$];
  logic [31:0] got[$];
  logic [31:0] pushed[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;
  bit run_known = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    pnding = (fq.size() != 0);
    fdata  = pnding ? fq[0] : '0;
  endtask

  task automatic push(logic [31:0] w);
    if (fq.size() < 4) fq.push_back(w);
    refresh();
  endtask

  task automatic tick();
    logic        pop_s, hs_s;
    logic [31:0] d_s, w;
    #1;
    pop_s = pop;
    hs_s  = valid & ready;
    d_s   = data;
    if (run_known) begin
      check("pop_rule", 32'(pop), 32'(pnding && (sb.size() < 2)));
      check("valid_model", 32'(valid), 32'(sb.size() != 0));
      if (sb.size() != 0) check("data_model", data, sb[0]);
    end
    @(posedge clk);
    #1;
    if (hs_s) begin
      got.push_back(d_s);
      if (run_known && sb.size() != 0) w = sb.pop_front();
    end
    if (pop_s && fq.size() != 0) begin
      w = fq.pop_front();
      pops++;
      if (run_known) sb.push_back(w);
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete(); sb.delete(); pushed.delete();
    pops = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[4];
    int dones;
    bit seen_valid;
    fq.delete();
    refresh();
    @(negedge clk);

    // reset state
    do_reset();
    check("rst_valid", 32'(valid), 0);
    check("rst_pop", 32'(pop), 0);
    check("rst_data", data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_done", 32'(done), 0);

    // in-order streaming, latency and 1 word/cycle throughput
    for (int i = 0; i < 4; i++) push(32'hA + 32'(i));
    en = 1'b1; ready = 1'b1;
    tick();
    check("lat_pre", 32'(valid), 0);
    tick();
    check("lat_valid", 32'(valid), 1);
    check("lat_data", data, 32'hA);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("thru_data", data, 32'hA + 32'(k));
    end
    tick();
    check("drain_valid", 32'(valid), 0);
    check("s1_got_n", 32'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("s1_order", got[i], 32'hA + 32'(i));
    check("s1_pops", 32'(pops), 4);
    check("s1_cnt", 32'(cnt), 4);
    check("s1_pnding", 32'(pnding), 0);
    en = 1'b0;
    tick();
    check("s1_busy", 32'(busy), 0);

    // backpressure: buffer fills to 2, head held
    do_reset();
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; push(w[i]); end
    en = 1'b1; ready = 1'b0;
    repeat (6) tick();
    check("bp_pops", 32'(pops), 2);
    check("bp_valid", 32'(valid), 1);
    check("bp_data", data, w[0]);
    check("bp_fifo_left", 32'(fq.size()), 2);
    ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 4; i++) tick();
    check("bp_got_n", 32'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("bp_order", got[i], w[i]);
    check("bp_cnt", 32'(cnt), 4);

    // flush from IDLE with a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) push($urandom);
    ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    dones = 0; seen_valid = 0;
    repeat (12) begin
      tick();
      if (done) dones++;
      if (valid) seen_valid = 1;
    end
    check("fl_pops", 32'(pops), 4);
    check("fl_done", 32'(dones), 1);
    check("fl_pnding", 32'(pnding), 0);
    check("fl_cnt", 32'(cnt), 0);
    check("fl_valid", 32'(seen_valid), 0);
    check("fl_busy", 32'(busy), 0);

    // flush wins over en in the same cycle
    do_reset();
    push($urandom); push($urandom);
    en = 1'b1; flush = 1'b1; ready = 1'b1;
    tick();
    en = 1'b0; flush = 1'b0;
    dones = 0; seen_valid = valid;
    repeat (10) begin
      tick();
      if (done) dones++;
      if (valid) seen_valid = 1;
    end
    check("pri_pops", 32'(pops), 2);
    check("pri_done", 32'(dones), 1);
    check("pri_valid", 32'(seen_valid), 0);
    check("pri_busy", 32'(busy), 0);

    // reset mid-stream with a full buffer
    do_reset();
    for (int i = 0; i < 4; i++) push($urandom);
    en = 1'b1;
    repeat (4) tick();
    check("mid_pre_valid", 32'(valid), 1);
    rst = 1'b1;
    tick();
    check("mid_valid", 32'(valid), 0);
    check("mid_cnt", 32'(cnt), 0);
    check("mid_pop", 32'(pop), 0);
    check("mid_fifo", 32'(fq.size()), 2);
    check("mid_pnding", 32'(pnding), 1);
    rst = 1'b0; en = 1'b0;
    tick();
    fq.delete(); refresh();

    // random traffic against the scoreboard; counter saturates at 7
    do_reset();
    en = 1'b1;
    tick();
    run_known = 1;
    for (int i = 0; i < 400 && got.size() < 9; i++) begin
      if (fq.size() < 4 && $urandom_range(0, 1) == 1) begin
        w[0] = $urandom;
        pushed.push_back(w[0]);
        push(w[0]);
      end
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    run_known = 0;
    check("rnd_got_n", 32'(got.size() >= 9), 1);
    for (int i = 0; i < got.size() && i < pushed.size(); i++) check("rnd_order", got[i], pushed[i]);
    check("rnd_cnt_sat", 32'(cnt), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
